ahb2axi_cmd: RTL
================

AHB2AXI_CMD -- requirements
Module: ahb2axi_cmd

Interface
REQ-001 Parameters (name, default, meaning): ID_BITS, 4, AXI ID width; ADDR_BITS, 32, address width; CMD_DEPTH, 4, command FIFO entries (power of 2); AXI_ID, 0, constant ID on every command.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-004 HSEL  input  1  slave select.
REQ-005 HTRANS  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-006 HWRITE / HADDR / HBURST / HSIZE  input  1 / ADDR_BITS / 3 / 3  address-phase controls.
REQ-007 HREADY  input  1  bus-level ready; address phase sampled only when high.
REQ-008 HREADYOUT  output  1  command-side ready; the data path combines it with its own ready externally.
REQ-009 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-010 AWID / AWADDR / AWLEN / AWSIZE / AWVALID  output  ID_BITS / ADDR_BITS / 4 / 2 / 1  AXI write-address channel.
REQ-011 AWREADY  input  1  AXI write-address accept.
REQ-012 ARID / ARADDR / ARLEN / ARSIZE / ARVALID  output  ID_BITS / ADDR_BITS / 4 / 2 / 1  AXI read-address channel.
REQ-013 ARREADY  input  1  AXI read-address accept.
REQ-014 dcmd_valid / dcmd_read / dcmd_len  output  1 / 1 / 4  one-cycle pulse to the data path on each AXI address handshake, carrying direction and length.

Function
REQ-015 Command start: HSEL & HREADY & HTRANS==NONSEQ. SEQ, IDLE and BUSY are ignored by this block.
REQ-016 Length mapping: HBURST SINGLE(0)->0, INCR4(3)->3, INCR8(5)->7, INCR16(7)->15.
REQ-017 err is set for HBURST INCR(1) or any WRAP (2,4,6).
REQ-018 err is set for HSIZE>3'b011.
REQ-019 err is set for misalignment: HSIZE=1 & HADDR[0]!=0; HSIZE=2 & HADDR[1:0]!=0; HSIZE=3 & HADDR[2:0]!=0.
REQ-020 FIFO entry fields: {HADDR, len, HSIZE[1:0], read=~HWRITE}, width ADDR_BITS+7. Only commands with err=0 are pushed.
REQ-021 FSM states: IDLE, STALL, ERR1, ERR2.
REQ-022 IDLE, valid start with err=1 -> ERR1; nothing pushed.
REQ-023 IDLE, valid start with err=0 and FIFO not full -> push in the same cycle; stay IDLE.
REQ-024 IDLE, valid start with err=0 and FIFO full -> capture the command in a pending register; go to STALL.
REQ-025 STALL: HREADYOUT=0. Push the pending command on the first cycle the registered full flag is low, then go to IDLE. A pop in a cycle does not free space for a push in that same cycle.
REQ-026 ERR1: HREADYOUT=0, HRESP=1, then go to ERR2.
REQ-027 ERR2: HREADYOUT=1, HRESP=1, then go to IDLE. A start sampled in ERR2 is processed as in IDLE.
REQ-028 In IDLE: HREADYOUT=1, HRESP=0.
REQ-029 FIFO head routing: the head is presented on AR when read=1, otherwise on AW.
REQ-030 Only the channel matching the head's direction asserts VALID. Commands issue strictly in FIFO order; a stalled AW blocks a later AR, and the reverse.
REQ-031 VALID rises the cycle after the head becomes available (registered outputs). Once high, VALID and payload stay stable until the READY handshake.
REQ-032 A handshake pops the FIFO and pulses dcmd_valid in the same cycle. The next head may assert VALID in the following cycle, giving 1 command per 2 cycles maximum.
REQ-033 AWID=ARID=AXI_ID. AxSIZE is HSIZE[1:0]. AxADDR is HADDR unchanged.
REQ-034 FIFO pointers are log2(CMD_DEPTH)+1 bits and wrap naturally; full and empty are derived from the MSB-differing comparison.
REQ-035 Push and pop in the same cycle on a non-full, non-empty FIFO keeps the occupancy unchanged.

Reset
REQ-036 On reset: FSM=IDLE, FIFO empty, pending register cleared, HREADYOUT=1, HRESP=0, AWVALID=ARVALID=0, dcmd_valid=0; AWADDR/ARADDR/AWLEN/ARLEN/AWSIZE/ARSIZE=0.
REQ-037 Reset asserted mid-operation (STALL, ERR1 or VALID high) discards all queued and pending commands. VALID drops in the next cycle regardless of READY.

Verification
REQ-038 NONSEQ write, HBURST=INCR8, HSIZE=2, HADDR=0x1000, AWREADY=1 -> AWVALID high 1 cycle after push; AWADDR=0x1000, AWLEN=7, AWSIZE=2; dcmd_valid pulse with dcmd_read=0, dcmd_len=7.
REQ-039 NONSEQ read, HBURST=WRAP4 -> HREADYOUT=0 & HRESP=1 for one cycle, then HREADYOUT=1 & HRESP=1 for one cycle; no ARVALID.
REQ-040 AWREADY=0 held, 5 NONSEQ SINGLE writes with CMD_DEPTH=4 -> 4 entries queued, 5th gives STALL with HREADYOUT=0; releasing AWREADY drains the commands in order, HREADYOUT returns to 1 after the 5th push.
REQ-041 Write at 0x0 then read at 0x40 with AWREADY=0 -> ARVALID stays 0 until the AW handshake, then ARVALID=1 with ARADDR=0x40.
REQ-042 HSIZE=1, HADDR=0x3 -> misalignment error response; reset asserted while in STALL -> next cycle AWVALID=0, HREADYOUT=1, FIFO empty.

Source files
------------

// File: rtl/ahb2axi_cmd.sv
// AHB address-phase to AXI AW/AR command bridge.
// Legal NONSEQ starts are queued in a small FIFO and issued in order on the
// AXI channel matching each command's direction. Illegal starts get a
// two-cycle AHB ERROR response. When the FIFO is full, the AHB side stalls
// with the command held in a pending register.
module ahb2axi_cmd #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int CMD_DEPTH = 4,
    parameter int AXI_ID    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 HSEL,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [ADDR_BITS-1:0] HADDR,
    input  logic [2:0]           HBURST,
    input  logic [2:0]           HSIZE,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [ID_BITS-1:0]   AWID,
    output logic [ADDR_BITS-1:0] AWADDR,
    output logic [3:0]           AWLEN,
    output logic [1:0]           AWSIZE,
    output logic                 AWVALID,
    input  logic                 AWREADY,
    output logic [ID_BITS-1:0]   ARID,
    output logic [ADDR_BITS-1:0] ARADDR,
    output logic [3:0]           ARLEN,
    output logic [1:0]           ARSIZE,
    output logic                 ARVALID,
    input  logic                 ARREADY,
    output logic                 dcmd_valid,
    output logic                 dcmd_read,
    output logic [3:0]           dcmd_len
);

    localparam int PTR_BITS   = $clog2(CMD_DEPTH);
    localparam int ENTRY_BITS = ADDR_BITS + 7;

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_ERR1, S_ERR2} state_t;

    state_t state_q, state_d;

    // Decoded address phase
    logic                  start;
    logic                  burst_err;
    logic                  align_err;
    logic                  cmd_err;
    logic [3:0]            cmd_len;
    logic [ENTRY_BITS-1:0] new_entry;

    // FIFO
    logic [ENTRY_BITS-1:0] mem_q [CMD_DEPTH];
    logic [PTR_BITS:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0]     rd_ptr_q, rd_ptr_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [ENTRY_BITS-1:0] push_data;
    logic [ENTRY_BITS-1:0] head;

    // Pending command held while stalled
    logic [ENTRY_BITS-1:0] pend_q, pend_d;
    logic                  pend_load;

    // Registered AXI command output stage
    logic                  aw_valid_q, aw_valid_d;
    logic                  ar_valid_q, ar_valid_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [1:0]            size_q, size_d;
    logic                  read_q, read_d;
    logic                  handshake;

    assign start = HSEL & HREADY & (HTRANS == 2'b10);

    // Burst-to-length mapping; unsupported bursts flag an error
    always_comb begin
        cmd_len   = '0;
        burst_err = 1'b0;
        case (HBURST)
            3'd0:    cmd_len = 4'd0;
            3'd3:    cmd_len = 4'd3;
            3'd5:    cmd_len = 4'd7;
            3'd7:    cmd_len = 4'd15;
            default: burst_err = 1'b1;
        endcase
    end

    // Address must be aligned to the transfer size
    always_comb begin
        align_err = 1'b0;
        case (HSIZE)
            3'd1:    align_err = HADDR[0];
            3'd2:    align_err = |HADDR[1:0];
            3'd3:    align_err = |HADDR[2:0];
            default: align_err = 1'b0;
        endcase
    end

    assign cmd_err   = burst_err | HSIZE[2] | align_err;
    assign new_entry = {HADDR, cmd_len, HSIZE[1:0], ~HWRITE};

    // Full/empty come from the registered pointers, so a pop never frees
    // space for a push in the same cycle.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                        (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    // AHB response FSM: next state, FIFO push and slave response
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = new_entry;
        pend_load = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            S_IDLE, S_ERR2: begin
                HRESP   = (state_q == S_ERR2);
                state_d = S_IDLE;
                if (start) begin
                    if (cmd_err) begin
                        state_d = S_ERR1;
                    end else if (!fifo_full) begin
                        push = 1'b1;
                    end else begin
                        pend_load = 1'b1;
                        state_d   = S_STALL;
                    end
                end
            end
            S_STALL: begin
                HREADYOUT = 1'b0;
                push_data = pend_q;
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = S_ERR2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Pending command next value
    always_comb begin
        pend_d = pend_q;
        if (pend_load) pend_d = new_entry;
    end

    // Pending command register
    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_data;
    end

    // FIFO pointer next values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // FIFO pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign handshake = (aw_valid_q & AWREADY) | (ar_valid_q & ARREADY);
    assign pop       = handshake;

    // Output stage: load the head when idle, hold until handshake, then
    // drop VALID for one cycle before presenting the next head.
    always_comb begin
        aw_valid_d = aw_valid_q;
        ar_valid_d = ar_valid_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        read_d     = read_q;
        if (handshake) begin
            aw_valid_d = 1'b0;
            ar_valid_d = 1'b0;
        end else if (!aw_valid_q && !ar_valid_q && !fifo_empty) begin
            addr_d     = head[ENTRY_BITS-1:7];
            len_d      = head[6:3];
            size_d     = head[2:1];
            read_d     = head[0];
            aw_valid_d = ~head[0];
            ar_valid_d = head[0];
        end
    end

    // Output stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_valid_q <= 1'b0;
            ar_valid_q <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            read_q     <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            ar_valid_q <= ar_valid_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            read_q     <= read_d;
        end
    end

    assign AWID       = ID_BITS'(AXI_ID);
    assign ARID       = ID_BITS'(AXI_ID);
    assign AWADDR     = addr_q;
    assign ARADDR     = addr_q;
    assign AWLEN      = len_q;
    assign ARLEN      = len_q;
    assign AWSIZE     = size_q;
    assign ARSIZE     = size_q;
    assign AWVALID    = aw_valid_q;
    assign ARVALID    = ar_valid_q;
    assign dcmd_valid = handshake & ~reset;
    assign dcmd_read  = read_q;
    assign dcmd_len   = len_q;

endmodule
